// File: rtl/prbs_pattern_gen.sv
// rtl/prbs_pattern_gen.sv - PRBS15 preamble followed by a repeated 32-bit pattern, byte stream with ready/valid
module prbs_pattern_gen #(
  parameter logic [14:0] SEED = 15'h7FFF
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic [31:0] pattern,
  input  logic [7:0]  n_repeats,
  input  logic [7:0]  prbs_bytes,
  input  logic        out_ready,
  output logic [7:0]  data_out,
  output logic        data_valid,
  output logic        busy,
  output logic        done
);

  localparam logic [14:0] SEED_EFF = (SEED == 15'd0) ? 15'h0001 : SEED;

  typedef enum logic [1:0] {IDLE, PRBS, PAT, DONE} state_t;

  // Eight steps of x^15+x^14+1; the low byte of the result is the emitted byte, first bit in [7].
  function automatic logic [14:0] adv8(input logic [14:0] s);
    logic [14:0] t;
    t = s;
    for (int i = 0; i < 8; i++) begin
      t = {t[13:0], t[14] ^ t[13]};
    end
    return t;
  endfunction

  function automatic logic [7:0] pat_byte(input logic [31:0] p, input logic [1:0] idx);
    logic [7:0] b;
    case (idx)
      2'd0:    b = p[31:24];
      2'd1:    b = p[23:16];
      2'd2:    b = p[15:8];
      default: b = p[7:0];
    endcase
    return b;
  endfunction

  state_t      state_q;
  logic [14:0] lfsr_q;
  logic [31:0] pat_q;
  logic [7:0]  nrep_q;
  logic [7:0]  nprbs_q;
  logic [7:0]  byte_cnt_q;
  logic [7:0]  word_cnt_q;
  logic [1:0]  idx_q;
  logic [7:0]  data_out_q;
  logic        valid_q;
  logic        busy_q;
  logic        done_q;

  // lfsr_q always holds the state before the byte currently presented.
  logic [14:0] lfsr_d;
  logic [14:0] lfsr_dd;
  assign lfsr_d  = adv8(lfsr_q);
  assign lfsr_dd = adv8(lfsr_d);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      lfsr_q     <= SEED_EFF;
      pat_q      <= 32'h0;
      nrep_q     <= 8'h0;
      nprbs_q    <= 8'h0;
      byte_cnt_q <= 8'h0;
      word_cnt_q <= 8'h0;
      idx_q      <= 2'd0;
      data_out_q <= 8'h00;
      valid_q    <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          done_q <= 1'b0;
          if (start) begin
            pat_q      <= pattern;
            nrep_q     <= n_repeats;
            nprbs_q    <= prbs_bytes;
            byte_cnt_q <= 8'h0;
            word_cnt_q <= 8'h0;
            idx_q      <= 2'd0;
            if (prbs_bytes != 8'd0) begin
              state_q    <= PRBS;
              data_out_q <= lfsr_d[7:0];
              valid_q    <= 1'b1;
              busy_q     <= 1'b1;
            end else if (n_repeats != 8'd0) begin
              state_q    <= PAT;
              data_out_q <= pattern[31:24];
              valid_q    <= 1'b1;
              busy_q     <= 1'b1;
            end else begin
              state_q <= DONE;
              done_q  <= 1'b1;
            end
          end
        end
        PRBS: begin
          if (out_ready) begin
            lfsr_q <= lfsr_d;
            if (byte_cnt_q == nprbs_q - 8'd1) begin
              if (nrep_q != 8'd0) begin
                state_q    <= PAT;
                idx_q      <= 2'd0;
                data_out_q <= pat_q[31:24];
              end else begin
                state_q    <= DONE;
                data_out_q <= 8'h00;
                valid_q    <= 1'b0;
                busy_q     <= 1'b0;
                done_q     <= 1'b1;
              end
            end else begin
              byte_cnt_q <= byte_cnt_q + 8'd1;
              data_out_q <= lfsr_dd[7:0];
            end
          end
        end
        PAT: begin
          if (out_ready) begin
            if (idx_q == 2'd3) begin
              if (word_cnt_q == nrep_q - 8'd1) begin
                state_q    <= DONE;
                data_out_q <= 8'h00;
                valid_q    <= 1'b0;
                busy_q     <= 1'b0;
                done_q     <= 1'b1;
              end else begin
                word_cnt_q <= word_cnt_q + 8'd1;
                idx_q      <= 2'd0;
                data_out_q <= pat_q[31:24];
              end
            end else begin
              idx_q      <= idx_q + 2'd1;
              data_out_q <= pat_byte(pat_q, idx_q + 2'd1);
            end
          end
        end
        DONE: begin
          done_q  <= 1'b0;
          state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign data_out   = data_out_q;
  assign data_valid = valid_q;
  assign busy       = busy_q;
  assign done       = done_q;

endmodule

// File: tb/tb_prbs_pattern_gen.sv
// tb/tb_prbs_pattern_gen.sv - scoreboard bench for prbs_pattern_gen against a byte-list reference model
module tb_prbs_pattern_gen;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic [31:0] pattern;
  logic [7:0]  n_repeats;
  logic [7:0]  prbs_bytes;
  logic        out_ready;
  logic [7:0]  data_out;
  logic        data_valid;
  logic        busy;
  logic        done;

  int errors = 0;
  int checks = 0;
  int unsigned m_lfsr;
  logic [7:0] got[$];

  prbs_pattern_gen dut (
    .clk(clk), .rst_n(rst_n), .start(start), .pattern(pattern),
    .n_repeats(n_repeats), .prbs_bytes(prbs_bytes), .out_ready(out_ready),
    .data_out(data_out), .data_valid(data_valid), .busy(busy), .done(done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Reference PRBS: bit-serial walk of x^15+x^14+1, first generated bit is the byte MSB.
  function automatic logic [7:0] model_prbs_byte();
    int unsigned b = 0;
    int unsigned nb;
    for (int i = 0; i < 8; i++) begin
      nb = ((m_lfsr >> 14) ^ (m_lfsr >> 13)) & 1;
      m_lfsr = ((m_lfsr << 1) | nb) & 32'h7FFF;
      b = (b << 1) | nb;
    end
    return b[7:0];
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // mode 0: ready always 1; mode 1: random ready; mode 2: ready low 3 cycles on byte index 1
  task automatic burst(input logic [7:0] np, input logic [7:0] nr, input logic [31:0] pat,
                       input int mode, input bit inject);
    logic [7:0] exp[$];
    int idx = 0;
    int cyc = 1;
    int stalls = 0;
    int stall_b1 = 0;
    bit fin = 0;
    got.delete();
    for (int i = 0; i < int'(np); i++) exp.push_back(model_prbs_byte());
    for (int w = 0; w < int'(nr); w++)
      for (int b = 0; b < 4; b++) exp.push_back(pat[31-8*b -: 8]);
    start = 1'b1; pattern = pat; n_repeats = nr; prbs_bytes = np;
    tick();
    start = 1'b0; pattern = $urandom; n_repeats = 8'($urandom); prbs_bytes = 8'($urandom);
    while (!fin && cyc < 5000) begin
      if (done) begin
        check("done_cycle", cyc, exp.size() + stalls + 1);
        check("byte_count", idx, exp.size());
        check("valid_in_done", data_valid, 1'b0);
        check("busy_in_done", busy, 1'b0);
        fin = 1;
        start = 1'b0;
      end else begin
        check("valid", data_valid, idx < exp.size());
        check("busy", busy, idx < exp.size());
        if (data_valid && idx < exp.size()) check("data", data_out, exp[idx]);
        case (mode)
          0: out_ready = 1'b1;
          1: out_ready = ($urandom % 4) != 0;
          default: begin
            if (data_valid && idx == 1 && stall_b1 < 3) begin
              out_ready = 1'b0;
              stall_b1++;
            end else out_ready = 1'b1;
          end
        endcase
        if (data_valid && !out_ready) stalls++;
        if (data_valid && out_ready) begin
          got.push_back(data_out);
          idx++;
        end
        if (inject && ($urandom % 4) == 0) begin
          start = 1'b1; pattern = $urandom;
          n_repeats = 8'($urandom); prbs_bytes = 8'($urandom);
        end else start = 1'b0;
      end
      tick();
      cyc++;
    end
    start = 1'b0;
    if (!fin) check("burst_timeout", 32'd0, 32'd1);
    check("done_pulse_one_cycle", done, 1'b0);
    check("idle_valid", data_valid, 1'b0);
  endtask

  initial begin
    rst_n = 1'b0; start = 1'b0; pattern = 32'h0; n_repeats = 8'h0;
    prbs_bytes = 8'h0; out_ready = 1'b0;
    m_lfsr = 32'h7FFF;
    tick(); tick();
    check("rst_data_out", data_out, 8'h00);
    check("rst_valid", data_valid, 1'b0);
    check("rst_busy", busy, 1'b0);
    check("rst_done", done, 1'b0);
    rst_n = 1'b1;
    tick();

    burst(8'd2, 8'd0, 32'h0, 0, 0);
    check("prbs_first_count", got.size(), 2);
    check("prbs_byte0", (got.size() > 0) ? got[0] : 8'hxx, 8'h00);
    check("prbs_byte1", (got.size() > 1) ? got[1] : 8'hxx, 8'h02);

    burst(8'd0, 8'd2, 32'hDEADBEEF, 0, 0);
    burst(8'd0, 8'd2, 32'hDEADBEEF, 2, 0);
    burst(8'd0, 8'd0, 32'h12345678, 0, 0);
    burst(8'd3, 8'd1, 32'hA5A5C3C3, 1, 1);

    // Reset in the middle of a pattern word, with start pulses while busy and during reset.
    start = 1'b1; pattern = 32'hDEADBEEF; n_repeats = 8'd2; prbs_bytes = 8'd0; out_ready = 1'b1;
    tick();
    for (int i = 0; i < 3; i++) begin
      check("pat_before_reset_valid", data_valid, 1'b1);
      start = 1'b1; pattern = $urandom; prbs_bytes = 8'd5; n_repeats = 8'd5;
      tick();
    end
    rst_n = 1'b0; start = 1'b1;
    tick();
    check("midrst_data_out", data_out, 8'h00);
    check("midrst_valid", data_valid, 1'b0);
    check("midrst_busy", busy, 1'b0);
    check("midrst_done", done, 1'b0);
    rst_n = 1'b1; start = 1'b0;
    tick();
    check("post_rst_valid", data_valid, 1'b0);
    check("post_rst_busy", busy, 1'b0);
    m_lfsr = 32'h7FFF;
    burst(8'd2, 8'd0, 32'h0, 1, 1);
    check("seed_reload_byte0", (got.size() > 0) ? got[0] : 8'hxx, 8'h00);
    check("seed_reload_byte1", (got.size() > 1) ? got[1] : 8'hxx, 8'h02);

    for (int k = 0; k < 6; k++) begin
      burst(8'($urandom_range(0, 20)), 8'($urandom_range(0, 6)), $urandom, 1, 1);
    end
    burst(8'd10, 8'd8, 32'hA5A5C3C3, 1, 0);
    burst(8'd255, 8'd255, $urandom, 0, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
